approx_error_monitor: RTL and testbench

APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

---
 rtl/approx_error_monitor.sv | 144 ++++++++++++++
 tb/tb_approx_error_monitor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/approx_error_monitor.sv
// Windowed error statistics for an approximate adder: per-window count, sum of
// absolute errors, sum of squared errors, peak absolute error and nonzero count.
module approx_error_monitor #(
   parameter int WINDOW_LOG2 = 10
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] appx,
   input  logic [31:0] accr,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [16:0] cnt,
   output logic [63:0] sae,
   output logic [95:0] sse,
   output logic [32:0] max_ae,
   output logic [16:0] nz_cnt
);

   localparam logic [16:0] WIN_LAST = 17'((64'd1 << WINDOW_LOG2) - 64'd1);

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DRAIN  = 2'd1,
      REPORT = 2'd2
   } state_t;

   // Both operands sign-extended to 33 bits, so the difference never wraps.
   function automatic logic [32:0] abs_err(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] d;
      d = {a[31], a} - {b[31], b};
      return d[32] ? (33'd0 - d) : d;
   endfunction

   state_t      state_r, state_s;
   logic [1:0]  drain_cnt_r;
   logic [16:0] win_cnt_r;
   logic        in_ready_r, out_valid_r;
   logic        in_xfer_s, out_xfer_s;
   logic        s1_valid_r, s1_nz_r;
   logic [32:0] s1_ae_r;
   logic [65:0] sq_s;
   logic [16:0] cnt_r, nz_r;
   logic [63:0] sae_r;
   logic [95:0] sse_r;
   logic [32:0] max_r;

   assign in_xfer_s  = in_valid & in_ready_r;
   assign out_xfer_s = out_valid_r & out_ready;
   assign sq_s       = {33'd0, s1_ae_r} * {33'd0, s1_ae_r};

   // Next-state logic; DRAIN waits until the last sample has left stage 2.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ACCUM: begin
            if (flush || (in_xfer_s && (win_cnt_r == WIN_LAST))) state_s = DRAIN;
            else                                                  state_s = ACCUM;
         end
         DRAIN: begin
            if (drain_cnt_r == 2'd2) state_s = REPORT;
            else                     state_s = DRAIN;
         end
         REPORT: begin
            if (out_xfer_s) state_s = ACCUM;
            else            state_s = REPORT;
         end
         default: state_s = ACCUM;
      endcase
   end

   // State register, registered handshake outputs and window sample counter.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r     <= ACCUM;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         drain_cnt_r <= 2'd0;
         win_cnt_r   <= 17'd0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == ACCUM);
         out_valid_r <= (state_s == REPORT);
         drain_cnt_r <= (state_r == DRAIN) ? (drain_cnt_r + 2'd1) : 2'd0;
         if (state_r != ACCUM) win_cnt_r <= 17'd0;
         else if (in_xfer_s)   win_cnt_r <= win_cnt_r + 17'd1;
         else                  win_cnt_r <= win_cnt_r;
      end
   end

   // Stage 1: absolute error and nonzero flag.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         s1_valid_r <= 1'b0;
         s1_ae_r    <= 33'd0;
         s1_nz_r    <= 1'b0;
      end else begin
         s1_valid_r <= in_xfer_s;
         s1_ae_r    <= in_xfer_s ? abs_err(appx, accr) : 33'd0;
         s1_nz_r    <= in_xfer_s && (appx != accr);
      end
   end

   // Stage 2: accumulators, cleared when the report is taken.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_r <= 17'd0;
         nz_r  <= 17'd0;
         sae_r <= 64'd0;
         sse_r <= 96'd0;
         max_r <= 33'd0;
      end else if (out_xfer_s) begin
         cnt_r <= 17'd0;
         nz_r  <= 17'd0;
         sae_r <= 64'd0;
         sse_r <= 96'd0;
         max_r <= 33'd0;
      end else if (s1_valid_r) begin
         cnt_r <= cnt_r + 17'd1;
         nz_r  <= nz_r + {16'd0, s1_nz_r};
         sae_r <= sae_r + {31'd0, s1_ae_r};
         sse_r <= sse_r + {30'd0, sq_s};
         if (s1_ae_r >= max_r) max_r <= s1_ae_r;
         else                  max_r <= max_r;
      end else begin
         cnt_r <= cnt_r;
         nz_r  <= nz_r;
         sae_r <= sae_r;
         sse_r <= sse_r;
         max_r <= max_r;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign cnt       = cnt_r;
   assign sae       = sae_r;
   assign sse       = sse_r;
   assign max_ae    = max_r;
   assign nz_cnt    = nz_r;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Scoreboard bench for approx_error_monitor with a 4-sample window: directed
// windows push expected reports, a negedge monitor compares each taken report.
module tb_approx_error_monitor;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] appx, accr;
   logic [16:0] cnt, nz_cnt;
   logic [63:0] sae;
   logic [95:0] sse;
   logic [32:0] max_ae;

   typedef struct {
      logic [16:0] cnt;
      logic [63:0] sae;
      logic [95:0] sse;
      logic [32:0] mx;
      logic [16:0] nz;
   } rep_t;

   rep_t exp_q[$];
   int   total_cnt = 0;
   int   pass_cnt  = 0;

   approx_error_monitor #(.WINDOW_LOG2(2)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .appx(appx), .accr(accr), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .cnt(cnt), .sae(sae), .sse(sse),
      .max_ae(max_ae), .nz_cnt(nz_cnt)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [16:0] c, input logic [63:0] s, input logic [95:0] q,
                       input logic [32:0] m, input logic [16:0] n);
      rep_t r;
      r.cnt = c; r.sae = s; r.sse = q; r.mx = m; r.nz = n;
      exp_q.push_back(r);
   endtask

   // Sample one pair (optionally with coincident flush); returns at posedge+1.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic fl);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge Clk); #1; n++;
      end
      appx = a; accr = b; flush = fl; in_valid = 1'b1;
      @(posedge Clk); #1;
      in_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic flush_only();
      flush = 1'b1;
      @(posedge Clk); #1;
      flush = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge Clk); #1;
      end
      chk(name, 96'(exp_q.size()), 96'd0);
   endtask

   // Monitor: a report is taken on the next posedge whenever valid and ready are high here.
   always @(negedge Clk) begin
      if (Rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_report", 96'(cnt), 96'h1FFFF);
         end else begin
            rep_t r;
            r = exp_q.pop_front();
            chk("rep_cnt", 96'(cnt), 96'(r.cnt));
            chk("rep_sae", 96'(sae), 96'(r.sae));
            chk("rep_sse", sse, r.sse);
            chk("rep_max_ae", 96'(max_ae), 96'(r.mx));
            chk("rep_nz_cnt", 96'(nz_cnt), 96'(r.nz));
         end
      end
   end

   initial begin
      Rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      appx = 32'd0; accr = 32'd0;
      #12;
      chk("rst_in_ready", 96'(in_ready), 96'd0);
      chk("rst_out_valid", 96'(out_valid), 96'd0);
      chk("rst_cnt", 96'(cnt), 96'd0);
      chk("rst_sse", sse, 96'd0);
      #10 Rst_n = 1'b1;
      @(posedge Clk); #1;
      chk("release_in_ready", 96'(in_ready), 96'd1);

      // Full window closed by count, with latency of the report.
      push(17'd4, 64'd9, 96'd29, 33'd4, 17'd3);
      send(32'd10, 32'd10, 1'b0);
      send(32'd12, 32'd10, 1'b0);
      send(32'd7, 32'd10, 1'b0);
      send(-32'sd5, -32'sd1, 1'b0);
      chk("close_in_ready", 96'(in_ready), 96'd0);
      for (int k = 1; k <= 3; k++) begin
         @(posedge Clk); #1;
         chk("latency_out_valid", 96'(out_valid), (k == 3) ? 96'd1 : 96'd0);
      end
      wait_drain("win1_timeout");
      @(posedge Clk); #1;
      chk("after_report_in_ready", 96'(in_ready), 96'd1);

      // Ties on the peak error, full window.
      push(17'd4, 64'd18, 96'd84, 33'd5, 17'd4);
      send(32'd5, 32'd0, 1'b0);
      send(32'd0, 32'd5, 1'b0);
      send(-32'sd3, 32'd0, 1'b0);
      send(32'd9, 32'd4, 1'b0);
      wait_drain("win_tie_timeout");

      // Extreme operands, then a separate flush.
      push(17'd1, 64'hFFFFFFFF, 96'hFFFFFFFE00000001, 33'hFFFFFFFF, 17'd1);
      send(32'h7FFFFFFF, 32'h80000000, 1'b0);
      flush_only();
      wait_drain("win_extreme_timeout");

      // Empty window.
      push(17'd0, 64'd0, 96'd0, 33'd0, 17'd0);
      flush_only();
      wait_drain("win_empty_timeout");

      // Back-pressure: report held while out_ready is low.
      out_ready = 1'b0;
      push(17'd1, 64'd3, 96'd9, 33'd3, 17'd1);
      send(32'd5, 32'd2, 1'b1);
      for (int i = 0; i < 20 && !out_valid; i++) begin
         @(posedge Clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; appx = 32'd100; accr = 32'd0;
         chk("hold_out_valid", 96'(out_valid), 96'd1);
         chk("hold_in_ready", 96'(in_ready), 96'd0);
         chk("hold_cnt", 96'(cnt), 96'd1);
         chk("hold_sae", 96'(sae), 96'd3);
         @(posedge Clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain("win_hold_timeout");
      push(17'd1, 64'd0, 96'd0, 33'd0, 17'd0);
      send(32'd2, 32'd2, 1'b1);
      wait_drain("win_after_hold_timeout");

      // Reset mid-window discards partial results.
      send(32'd8, 32'd1, 1'b0);
      send(32'd9, 32'd1, 1'b0);
      send(32'd7, 32'd1, 1'b0);
      #3 Rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 96'(out_valid), 96'd0);
      chk("midrst_in_ready", 96'(in_ready), 96'd0);
      chk("midrst_cnt", 96'(cnt), 96'd0);
      chk("midrst_sae", 96'(sae), 96'd0);
      chk("midrst_max_ae", 96'(max_ae), 96'd0);
      #10 Rst_n = 1'b1;
      @(posedge Clk); #1;
      chk("midrst_release_in_ready", 96'(in_ready), 96'd1);
      push(17'd1, 64'd2, 96'd4, 33'd2, 17'd1);
      send(32'd3, 32'd1, 1'b1);
      wait_drain("win_post_rst_timeout");

      // Flush coincident with the closing sample.
      push(17'd2, 64'd6, 96'd36, 33'd6, 17'd1);
      send(32'd1, 32'd1, 1'b0);
      send(32'd0, 32'd6, 1'b1);
      wait_drain("win_coinc_timeout");

      repeat (3) @(posedge Clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
